step_input_conditioner: RTL and testbench

Upstream stage for the 4-bit up/down counter. It conditions the raw step push-button and the raw direction switch from the board. It outputs a one-cycle `step` pulse, which the counter uses as its count enable, and a debounced `ud` level. Pulses auto-repeat while the button is held, so the counter can be swept continuously.

---
 rtl/step_cond_pkg.sv | 19 +
 rtl/sync2.sv | 12 +
 rtl/step_input_conditioner.sv | 76 +++++++
 tb/tb_step_input_conditioner.sv | 127 ++++++++++++
 4 files changed

// File: rtl/step_cond_pkg.sv
// step_cond_pkg: shared state encoding, default timing and timer sizing for the step input conditioner.
package step_cond_pkg;
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_DB   = 3'd1,
    HELD       = 3'd2,
    REPEAT     = 3'd3,
    RELEASE_DB = 3'd4
  } btn_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous level, cleared by synchronous active-low reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] s_q;
  always_ff @(posedge clk)
    s_q <= !rst ? 2'b00 : {s_q[0], d_i};
  assign q_o = s_q[1];
endmodule

// File: rtl/step_input_conditioner.sv
// step_input_conditioner: debounces the step button into single-cycle (auto-repeating) pulses
// and the direction switch into a clean up/down level.
module step_input_conditioner
  import step_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit REPEAT_EN       = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  input  logic sw_ud,
  output logic step,
  output logic ud
);
  localparam int TW = tmr_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [TW-1:0] DB_LAST = TW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] RD_LAST = TW'(REPEAT_DELAY - 1);
  localparam logic [TW-1:0] RP_LAST = TW'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0] SW_LAST = CW'(DEBOUNCE_CYCLES);
  logic btn_s, sw_s;
  btn_state_e state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic step_q, step_d, ud_q, ud_d;
  sync2 u_btn_sync (.clk(clk), .rst(rst), .d_i(btn_in), .q_o(btn_s));
  sync2 u_sw_sync  (.clk(clk), .rst(rst), .d_i(sw_ud),  .q_o(sw_s));
  always_ff @(posedge clk)
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      step_q  <= 1'b0;
      ud_q    <= 1'b1;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      step_q  <= step_d;
      ud_q    <= ud_d;
      dcnt_q  <= dcnt_d;
    end
  // Release always wins over a timer expiry in the same cycle.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q + TW'(1);
    case (state_q)
      IDLE:       if (btn_s) state_d = PRESS_DB;
      PRESS_DB:   if (!btn_s) state_d = IDLE;
                  else if (tmr_q == DB_LAST) state_d = HELD;
      HELD:       if (!btn_s) state_d = RELEASE_DB;
                  else if (REPEAT_EN && tmr_q == RD_LAST) state_d = REPEAT;
                  else if (tmr_q == '1) tmr_d = tmr_q;
      REPEAT:     if (!btn_s) state_d = RELEASE_DB;
                  else if (tmr_q == RP_LAST) tmr_d = '0;
      RELEASE_DB: if (btn_s) tmr_d = '0;
                  else if (tmr_q == DB_LAST) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
    if (state_d != state_q || state_q == IDLE) tmr_d = '0;
  end
  always_comb begin
    step_d = btn_s && ((state_q == PRESS_DB && tmr_q == DB_LAST) ||
                       (state_q == HELD && REPEAT_EN && tmr_q == RD_LAST) ||
                       (state_q == REPEAT && tmr_q == RP_LAST));
  end
  // One extra stable sample so a direction change lands on the same edge as a step pulse.
  always_comb begin
    ud_d   = (sw_s != ud_q && dcnt_q == SW_LAST) ? ~ud_q : ud_q;
    dcnt_d = (sw_s == ud_q || ud_d != ud_q) ? '0 : dcnt_q + CW'(1);
  end
  assign step = step_q;
  assign ud   = ud_q;
endmodule

// File: tb/tb_step_input_conditioner.sv
// tb_step_input_conditioner: scoreboard bench driving a repeating and a one-shot instance in parallel.
module tb_step_input_conditioner;
  logic clk, rst, btn, sw;
  logic step1, ud1, step0, ud0;
  logic ud1_prev, ud0_prev;
  int cyc, n_chk, n_fail;
  int q1[$], q0[$], qu1[$], qu0[$];
  step_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b1), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_rep (
    .clk(clk), .rst(rst), .btn_in(btn), .sw_ud(sw), .step(step1), .ud(ud1));
  step_input_conditioner #(.DEBOUNCE_CYCLES(4), .REPEAT_EN(1'b0), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)) u_one (
    .clk(clk), .rst(rst), .btn_in(btn), .sw_ud(sw), .step(step0), .ud(ud0));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // A press whose first 1 is sampled on edge e0 and whose last 1 is sampled on edge e0+n-1.
  task automatic expect_press(input int e0, input int n);
    if (n + 1 >= 6) q0.push_back(e0 + 7);
    for (int k = 6; k <= n + 1; k = (k == 6) ? 14 : k + 3) q1.push_back(e0 + k + 1);
  endtask
  task automatic press(input int n);
    expect_press(cyc, n);
    btn = 1'b1;
    tick(n);
    btn = 1'b0;
    tick(20);
  endtask
  task automatic sw_change(input logic v);
    qu1.push_back((cyc + 7) * 2 + int'(v));
    qu0.push_back((cyc + 7) * 2 + int'(v));
    sw = v;
  endtask
  initial begin
    ud1_prev = 1'b1;
    ud0_prev = 1'b1;
  end
  always @(negedge clk) begin
    if (step1 !== 1'b0) chk("step_rep_pulse", cyc, q1.size() ? q1.pop_front() : -1);
    if (step0 !== 1'b0) chk("step_one_pulse", cyc, q0.size() ? q0.pop_front() : -1);
    if (ud1 !== ud1_prev) chk("ud_rep_change", cyc * 2 + int'(ud1), qu1.size() ? qu1.pop_front() : -1);
    if (ud0 !== ud0_prev) chk("ud_one_change", cyc * 2 + int'(ud0), qu0.size() ? qu0.pop_front() : -1);
    ud1_prev = ud1;
    ud0_prev = ud0;
  end
  initial begin
    int e0;
    n_chk = 0;
    n_fail = 0;
    rst = 1'b0;
    btn = 1'b0;
    sw = 1'b1;
    repeat (2) begin
      btn = 1'($urandom_range(0, 1));
      sw = 1'($urandom_range(0, 1));
      tick(1);
      chk("rst_step_rep", int'(step1), 0);
      chk("rst_step_one", int'(step0), 0);
      chk("rst_ud_rep", int'(ud1), 1);
      chk("rst_ud_one", int'(ud0), 1);
    end
    btn = 1'b0;
    sw = 1'b1;
    rst = 1'b1;
    repeat (3) begin
      tick(1);
      chk("post_rst_step_rep", int'(step1), 0);
      chk("post_rst_step_one", int'(step0), 0);
    end
    tick(5);
    press(20);
    btn = 1'b1;
    tick(3);
    btn = 1'b0;
    tick(1);
    press(12);
    sw_change(1'b0);
    tick(20);
    sw_change(1'b1);
    tick(20);
    sw = 1'b0;
    tick(2);
    sw = 1'b1;
    tick(20);
    fork
      press(30);
      begin
        tick(8);
        sw_change(1'b0);
        tick(12);
        sw_change(1'b1);
      end
    join
    e0 = cyc;
    q0.push_back(e0 + 7);
    q1.push_back(e0 + 7);
    q1.push_back(e0 + 15);
    q1.push_back(e0 + 18);
    btn = 1'b1;
    tick(18);
    rst = 1'b0;
    tick(1);
    chk("mid_rst_step_rep", int'(step1), 0);
    chk("mid_rst_step_one", int'(step0), 0);
    chk("mid_rst_ud_rep", int'(ud1), 1);
    rst = 1'b1;
    expect_press(cyc, 20);
    tick(20);
    btn = 1'b0;
    tick(20);
    while (q1.size()) chk("step_rep_missing", -1, q1.pop_front());
    while (q0.size()) chk("step_one_missing", -1, q0.pop_front());
    while (qu1.size()) chk("ud_rep_missing", -1, qu1.pop_front());
    while (qu0.size()) chk("ud_one_missing", -1, qu0.pop_front());
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
